// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: size-select encodings,
// strobe width and the layout of one queued store.
package store_pkg;

    localparam logic [1:0] SEL_SW = 2'b00;
    localparam logic [1:0] SEL_SB = 2'b01;
    localparam logic [1:0] SEL_SH = 2'b10;

    localparam int STRB_W = 4;
    localparam int WORD_W = 30;

    // The word address is held at full RV32 width; narrower AW is zero-extended.
    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [31:0]       wdata;
        logic [STRB_W-1:0] wstrb;
    } entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane steering for one store: low-aligned data plus size
// select and byte offset in, lane-positioned data, strobe and misalign flag out.
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [1:0]        addr_lo,
    input  logic [31:0]       data,
    output logic [31:0]       wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              misaligned
);

    always_comb begin
        wdata      = '0;
        wstrb      = '0;
        misaligned = 1'b0;
        case (sel)
            SEL_SB: begin
                wdata = {24'b0, data[7:0]} << {addr_lo, 3'b000};
                wstrb = 4'b0001 << addr_lo;
            end
            SEL_SH: begin
                wdata      = {16'b0, data[15:0]} << {addr_lo[1], 4'b0000};
                wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
                misaligned = addr_lo[0];
            end
            // SEL_SW and the unused 2'b11 encoding both behave as a word store.
            default: begin
                wdata      = data;
                wstrb      = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: lane-steers each store at enqueue and drains the FIFO
// to data memory over valid/ready. Optional load forwarding: STORE_BUFFER_FWD_EN.
module store_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [1:0]    st_sel,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    output logic          misalign,
    output logic          empty
`ifdef STORE_BUFFER_FWD_EN
    ,
    input  logic [AW-1:0] ld_addr,
    output logic          fwd_hit,
    output logic [31:0]   fwd_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready.
    // Valid never depends combinationally on ready on either side.
    entry_t          entries [DEPTH];
    entry_t          ent_in;
    entry_t          head;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;
    logic [31:0]     al_wdata;
    logic [3:0]      al_wstrb;
    logic            al_misaligned;
    logic            accept;
    logic            push;
    logic            pop;

    store_lane_align u_align (
        .sel        (st_sel),
        .addr_lo    (st_addr[1:0]),
        .data       (st_data),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .misaligned (al_misaligned)
    );

    always_comb begin
        ent_in       = '0;
        ent_in.addr  = WORD_W'(st_addr[AW-1:2]);
        ent_in.wdata = al_wdata;
        ent_in.wstrb = al_wstrb;
    end

    assign st_ready  = (count != FULL_COUNT);
    assign mem_valid = (count != '0);
    assign empty     = (count == '0);
    assign accept    = st_valid && st_ready;
    assign push      = accept && !al_misaligned;
    assign pop       = mem_valid && mem_ready;

    assign head      = entries[rd_ptr];
    // Head fields are masked so an idle bus reads all zeros.
    assign mem_addr  = mem_valid ? {(AW-2)'(head.addr), 2'b00} : '0;
    assign mem_wdata = mem_valid ? head.wdata : '0;
    assign mem_wstrb = mem_valid ? head.wstrb : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            // A dropped misaligned store still completes its handshake.
            misalign <= accept && al_misaligned;
        end
    end

    // Storage needs no reset: stale slots are never visible past count.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= ent_in;
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (((PW+1)'(i) < count) &&
                (entries[idx].addr == WORD_W'(ld_addr[AW-1:2]))) begin
                fwd_hit  = (entries[idx].wstrb == 4'b1111);
                fwd_data = (entries[idx].wstrb == 4'b1111) ? entries[idx].wdata : '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: table of single-store
// vectors plus hand-written fill/drain, streaming, and reset sequences.
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_sel;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        misalign;
    logic        empty;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {addr, wdata, wstrb}
    logic [67:0] exp_q[$];

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  sel;
        logic        mis;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t vecs[12];

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk       (clk),
        .reset     (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_sel    (st_sel),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .misalign  (misalign),
        .empty     (empty)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string name);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, mem_valid=%0b", name, mem_valid);
        end else begin
            chk({name, "_valid"}, 32'(mem_valid), 32'd1);
            chk({name, "_addr"},  mem_addr,       exp_q[0][67:36]);
            chk({name, "_wdata"}, mem_wdata,      exp_q[0][35:4]);
            chk({name, "_wstrb"}, 32'(mem_wstrb), 32'(exp_q[0][3:0]));
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; the store is taken on the following posedge.
    task automatic drive_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sel);
        st_valid = 1'b1;
        st_addr  = addr;
        st_data  = data;
        st_sel   = sel;
    endtask

    task automatic set_vec(input int i, input string n, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s, input logic m, input logic [31:0] ea,
                           input logic [31:0] ew, input logic [3:0] es);
        vecs[i].name = n; vecs[i].addr = a; vecs[i].data = d; vecs[i].sel = s; vecs[i].mis = m;
        vecs[i].exp_addr = ea; vecs[i].exp_wdata = ew; vecs[i].exp_wstrb = es;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;

        set_vec(0,  "sb_103",  32'h103, 32'h0000_00AB, 2'b01, 1'b0, 32'h100, 32'hAB00_0000, 4'b1000);
        set_vec(1,  "sb_100",  32'h100, 32'h0000_00AB, 2'b01, 1'b0, 32'h100, 32'h0000_00AB, 4'b0001);
        set_vec(2,  "sb_101",  32'h101, 32'hFFFF_FF5A, 2'b01, 1'b0, 32'h100, 32'h0000_5A00, 4'b0010);
        set_vec(3,  "sh_202",  32'h202, 32'h0000_BEEF, 2'b10, 1'b0, 32'h200, 32'hBEEF_0000, 4'b1100);
        set_vec(4,  "sh_200",  32'h200, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h200, 32'h0000_BEEF, 4'b0011);
        set_vec(5,  "sw_300",  32'h300, 32'h1234_5678, 2'b00, 1'b0, 32'h300, 32'h1234_5678, 4'b1111);
        set_vec(6,  "s11_304", 32'h304, 32'hCAFE_F00D, 2'b11, 1'b0, 32'h304, 32'hCAFE_F00D, 4'b1111);
        set_vec(7,  "sb_003",  32'h003, 32'h0000_0011, 2'b01, 1'b0, 32'h000, 32'h1100_0000, 4'b1000);
        set_vec(8,  "sw_101m", 32'h101, 32'h1111_1111, 2'b00, 1'b1, 32'h0,   32'h0,         4'b0000);
        set_vec(9,  "sh_001m", 32'h001, 32'h0000_2222, 2'b10, 1'b1, 32'h0,   32'h0,         4'b0000);
        set_vec(10, "sw_302m", 32'h302, 32'h3333_3333, 2'b00, 1'b1, 32'h0,   32'h0,         4'b0000);
        set_vec(11, "s11_301m",32'h301, 32'h4444_4444, 2'b11, 1'b1, 32'h0,   32'h0,         4'b0000);

        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_sel = '0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_empty",     32'(empty),     32'd1);
        chk("rst_st_ready",  32'(st_ready),  32'd1);
        chk("rst_misalign",  32'(misalign),  32'd0);
        chk("rst_mem_addr",  mem_addr,       32'd0);
        chk("rst_mem_wdata", mem_wdata,      32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);

        // Single-store vectors, memory always ready
        for (int i = 0; i < 12; i++) begin
            chk({vecs[i].name, "_st_ready"}, 32'(st_ready), 32'd1);
            drive_store(vecs[i].addr, vecs[i].data, vecs[i].sel);
            @(negedge clk);
            st_valid = 1'b0;
            chk({vecs[i].name, "_misalign"},  32'(misalign),  32'(vecs[i].mis));
            chk({vecs[i].name, "_mem_valid"}, 32'(mem_valid), 32'(!vecs[i].mis));
            chk({vecs[i].name, "_empty"},     32'(empty),     32'(vecs[i].mis));
            chk({vecs[i].name, "_addr"},      mem_addr,       vecs[i].exp_addr);
            chk({vecs[i].name, "_wdata"},     mem_wdata,      vecs[i].exp_wdata);
            chk({vecs[i].name, "_wstrb"},     32'(mem_wstrb), 32'(vecs[i].exp_wstrb));
            @(negedge clk);
            chk({vecs[i].name, "_empty_after"},    32'(empty),     32'd1);
            chk({vecs[i].name, "_misalign_after"}, 32'(misalign),  32'd0);
            chk({vecs[i].name, "_valid_after"},    32'(mem_valid), 32'd0);
        end

        // Fill to DEPTH with memory stalled, then drain in order
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("fill_st_ready", 32'(st_ready), 32'd1);
            a = 32'h400 + 32'(4 * i);
            d = 32'hA000_0000 | 32'(i);
            drive_store(a, d, 2'b00);
            exp_q.push_back({a, d, 4'b1111});
            @(negedge clk);
        end
        st_valid = 1'b0;
        chk("full_st_ready", 32'(st_ready), 32'd0);
        chk_head("full_head");
        @(negedge clk);
        chk_head("stall_head");
        chk("stall_st_ready", 32'(st_ready), 32'd0);
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_head("drain_head");
            void'(exp_q.pop_front());
            @(negedge clk);
            if (i == 0) chk("drain_st_ready", 32'(st_ready), 32'd1);
        end
        chk("drain_empty",     32'(empty),     32'd1);
        chk("drain_mem_valid", 32'(mem_valid), 32'd0);

        // Steady push+pop with two entries resident; pointers wrap several times
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = 32'h600 + 32'(4 * i);
            d = 32'h5000_0000 + 32'(i);
            drive_store(a, d, 2'b00);
            exp_q.push_back({a, d, 4'b1111});
            @(negedge clk);
        end
        st_valid  = 1'b0;
        mem_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            chk_head("stream_head");
            chk("stream_st_ready", 32'(st_ready), 32'd1);
            a = 32'h700 + 32'(4 * n);
            d = 32'h1000_0000 + 32'(n * 32'h111);
            drive_store(a, d, 2'b00);
            void'(exp_q.pop_front());
            exp_q.push_back({a, d, 4'b1111});
            @(negedge clk);
        end
        st_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_head("stream_tail");
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        chk("stream_empty", 32'(empty), 32'd1);

        // Asynchronous reset with three stores pending
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h800 + 32'(4 * i), 32'h7700_0000 + 32'(i), 2'b00);
            @(negedge clk);
        end
        st_valid = 1'b0;
        chk("pre_rst_valid", 32'(mem_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(mem_valid), 32'd0);
        chk("async_rst_empty", 32'(empty),     32'd1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        chk("post_rst_st_ready", 32'(st_ready), 32'd1);
        mem_ready = 1'b1;
        drive_store(32'h500, 32'h55AA_55AA, 2'b00);
        exp_q.push_back({32'h500, 32'h55AA_55AA, 4'b1111});
        @(negedge clk);
        st_valid = 1'b0;
        chk_head("post_rst_head");
        void'(exp_q.pop_front());
        @(negedge clk);
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
